// File: rtl/enemy_fleet_ctrl.sv
// Enemy formation sequencer: march pacing, edge drop/reverse,
// wave-clear and landing detection, round-robin enemy fire grants.
module enemy_fleet_ctrl #(
  parameter int unsigned num_enemies_p = 8,
  parameter int unsigned step_frames_p = 30,
  parameter int unsigned step_px_p     = 10,
  parameter int unsigned drop_px_p     = 10,
  parameter int unsigned right_limit_p = 629,
  parameter int unsigned left_limit_p  = 0,
  parameter int unsigned land_row_p    = 440,
  parameter int unsigned fire_frames_p = 60
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_i,
  input  logic                     start_i,
  input  logic [num_enemies_p-1:0] alive_i,
  input  logic [9:0]               fleet_left_i,
  input  logic [9:0]               fleet_right_i,
  input  logic [9:0]               fleet_bot_i,
  input  logic                     bullet_busy_i,
  output logic                     step_o,
  output logic                     dir_right_o,
  output logic                     drop_o,
  output logic [num_enemies_p-1:0] fire_grant_o,
  output logic                     wave_clear_o,
  output logic                     game_over_o,
  output logic                     marching_o
);

  localparam int unsigned IW =
    (num_enemies_p > 1) ? $clog2(num_enemies_p) : 1;
  localparam int unsigned SW = $clog2(step_frames_p + 1);
  localparam int unsigned FW = $clog2(fire_frames_p + 1);

  localparam logic [SW-1:0] STEP_LAST = SW'(step_frames_p - 1);
  localparam logic [FW-1:0] FIRE_LAST = FW'(fire_frames_p - 1);

  typedef enum logic [2:0] {
    IDLE,
    MARCH,
    DROP,
    CLEAR,
    OVER
  } state_e;

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic [SW-1:0]   step_cnt_q, step_cnt_d;
  logic [FW-1:0]   fire_cnt_q, fire_cnt_d;
  logic            pend_q, pend_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic            any_alive;
  logic            at_right;
  logic            at_left;
  logic            landed;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [IW:0]     probe;
  logic            do_grant;

  // 11-bit sums so a fleet near 1023 cannot wrap past a limit
  assign any_alive = |alive_i;
  assign at_right  = ({1'b0, fleet_right_i} + 11'(step_px_p))
                     > 11'(right_limit_p);
  assign at_left   = {1'b0, fleet_left_i}
                     < 11'(left_limit_p + step_px_p);
  assign landed    = ({1'b0, fleet_bot_i} + 11'(drop_px_p))
                     >= 11'(land_row_p);

  // First alive ship strictly after the pointer, wrapping
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    probe   = '0;
    for (int i = 1; i <= int'(num_enemies_p); i++) begin
      probe = {1'b0, ptr_q} + (IW+1)'(i);
      if (probe >= (IW+1)'(num_enemies_p)) begin
        probe = probe - (IW+1)'(num_enemies_p);
      end
      if (!hit && alive_i[probe[IW-1:0]]) begin
        hit     = 1'b1;
        hit_idx = probe[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    step_cnt_d = step_cnt_q;
    fire_cnt_d = fire_cnt_q;
    pend_d     = pend_q;
    ptr_d      = ptr_q;
    step_o     = 1'b0;
    drop_o     = 1'b0;
    do_grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        step_cnt_d = '0;
        fire_cnt_d = '0;
        pend_d     = 1'b0;
        dir_d      = 1'b1;
        if (start_i) state_d = MARCH;
      end
      MARCH: begin
        if (!any_alive) begin
          state_d    = CLEAR;
          step_cnt_d = '0;
          fire_cnt_d = '0;
          pend_d     = 1'b0;
        end else begin
          do_grant = pend_q && !bullet_busy_i && hit;
          pend_d   = pend_q && !do_grant;
          if (do_grant) ptr_d = hit_idx;
          if (frame_i) begin
            if (fire_cnt_q == FIRE_LAST) begin
              fire_cnt_d = '0;
              pend_d     = 1'b1;
            end else begin
              fire_cnt_d = fire_cnt_q + 1'b1;
            end
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_d = '0;
              if (dir_q ? at_right : at_left) begin
                state_d    = DROP;
                pend_d     = 1'b0;
                fire_cnt_d = '0;
              end else begin
                step_o = 1'b1;
              end
            end else begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
          end
        end
      end
      DROP: begin
        drop_o  = 1'b1;
        dir_d   = !dir_q;
        state_d = landed ? OVER : MARCH;
      end
      CLEAR: begin
        if (start_i) begin
          state_d    = MARCH;
          step_cnt_d = '0;
          fire_cnt_d = '0;
          pend_d     = 1'b0;
          dir_d      = 1'b1;
        end
      end
      OVER: begin
        if (start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      dir_q      <= 1'b1;
      step_cnt_q <= '0;
      fire_cnt_q <= '0;
      pend_q     <= 1'b0;
      ptr_q      <= IW'(num_enemies_p - 1);
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      step_cnt_q <= step_cnt_d;
      fire_cnt_q <= fire_cnt_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    fire_grant_o = '0;
    if (do_grant) fire_grant_o[hit_idx] = 1'b1;
  end

  assign dir_right_o  = dir_q;
  assign wave_clear_o = (state_q == CLEAR);
  assign game_over_o  = (state_q == OVER);
  assign marching_o   = (state_q == MARCH);

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// Bench for enemy_fleet_ctrl: per-scenario tasks, with fire grants
// checked against a queue of expected ship indices.
module tb_enemy_fleet_ctrl;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         frame_i = 1'b0;
  logic         start_i = 1'b0;
  logic [N-1:0] alive_i = '1;
  logic [9:0]   fleet_left_i = 10'd200;
  logic [9:0]   fleet_right_i = 10'd100;
  logic [9:0]   fleet_bot_i = 10'd100;
  logic         bullet_busy_i = 1'b1;
  logic         step_o;
  logic         dir_right_o;
  logic         drop_o;
  logic [N-1:0] fire_grant_o;
  logic         wave_clear_o;
  logic         game_over_o;
  logic         marching_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_grants = 0;
  int exp_q[$];
  logic [N-1:0] mon_want;

  enemy_fleet_ctrl #(
    .num_enemies_p(N),
    .step_frames_p(3),
    .step_px_p(10),
    .drop_px_p(10),
    .right_limit_p(629),
    .left_limit_p(0),
    .land_row_p(440),
    .fire_frames_p(2)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .frame_i(frame_i),
    .start_i(start_i),
    .alive_i(alive_i),
    .fleet_left_i(fleet_left_i),
    .fleet_right_i(fleet_right_i),
    .fleet_bot_i(fleet_bot_i),
    .bullet_busy_i(bullet_busy_i),
    .step_o(step_o),
    .dir_right_o(dir_right_o),
    .drop_o(drop_o),
    .fire_grant_o(fire_grant_o),
    .wave_clear_o(wave_clear_o),
    .game_over_o(game_over_o),
    .marching_o(marching_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every grant must match the next queued ship index
  always @(negedge clk_i) begin
    if (!reset_i && fire_grant_o !== '0) begin
      n_grants++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got %b, required none",
                 fire_grant_o);
      end else begin
        mon_want = '0;
        mon_want[exp_q.pop_front()] = 1'b1;
        if (fire_grant_o !== mon_want) begin
          n_fail++;
          $display("FAIL grant_order: got %b, required %b",
                   fire_grant_o, mon_want);
        end
      end
    end
  end

  task automatic cyc(input logic f, input logic s);
    @(posedge clk_i);
    #1;
    frame_i = f;
    start_i = s;
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    frame_i = 1'b0;
    start_i = 1'b0;
    exp_q.delete();
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    #2 reset_i = 1'b1;
    #1;
    n_checks++;
    if ({step_o, drop_o, wave_clear_o, game_over_o, marching_o}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000",
               {step_o, drop_o, wave_clear_o, game_over_o, marching_o});
    end
    n_checks++;
    if (dir_right_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dir: got %b, required 1", dir_right_o);
    end
    n_checks++;
    if (fire_grant_o !== '0) begin
      n_fail++;
      $display("FAIL reset_grant: got %b, required 0", fire_grant_o);
    end
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_march();
    apply_reset();
    bullet_busy_i = 1'b1;
    alive_i       = '1;
    fleet_right_i = 10'd100;
    fleet_left_i  = 10'd200;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    n_checks++;
    if (marching_o !== 1'b1) begin
      n_fail++;
      $display("FAIL march_enter: got %b, required 1", marching_o);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, 1'b0);
      n_checks++;
      if ({step_o, dir_right_o} !== {(k % 3 == 0), 1'b1}) begin
        n_fail++;
        $display("FAIL march_step%0d: got step=%b dir=%b, required %b 1",
                 k, step_o, dir_right_o, (k % 3 == 0));
      end
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_drop();
    fleet_right_i = 10'd625;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    n_checks++;
    if ({step_o, drop_o, marching_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL edge_nostep: got %b, required 001",
               {step_o, drop_o, marching_o});
    end
    cyc(1'b0, 1'b0);
    n_checks++;
    if ({drop_o, marching_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL drop_pulse: got %b, required 10",
               {drop_o, marching_o});
    end
    cyc(1'b0, 1'b0);
    n_checks++;
    if ({drop_o, dir_right_o, marching_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL drop_after: got %b, required 001",
               {drop_o, dir_right_o, marching_o});
    end
    fleet_right_i = 10'd100;
    fleet_left_i  = 10'd200;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    n_checks++;
    if ({step_o, dir_right_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL step_left: got %b, required 10",
               {step_o, dir_right_o});
    end
    #1 reset_i = 1'b1;
    #1;
    n_checks++;
    if ({step_o, dir_right_o, marching_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_midpulse: got %b, required 010",
               {step_o, dir_right_o, marching_o});
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    frame_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_over();
    apply_reset();
    bullet_busy_i = 1'b1;
    alive_i       = '1;
    fleet_right_i = 10'd625;
    fleet_bot_i   = 10'd435;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    n_checks++;
    if (drop_o !== 1'b1) begin
      n_fail++;
      $display("FAIL land_drop: got %b, required 1", drop_o);
    end
    cyc(1'b0, 1'b0);
    n_checks++;
    if ({game_over_o, marching_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL land_over: got %b, required 10",
               {game_over_o, marching_o});
    end
    bullet_busy_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0);
      n_checks++;
      if ({step_o, fire_grant_o, game_over_o} !== {1'b0, {N{1'b0}}, 1'b1})
      begin
        n_fail++;
        $display("FAIL over_quiet%0d: got step=%b grant=%b over=%b",
                 k, step_o, fire_grant_o, game_over_o);
      end
    end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    n_checks++;
    if ({game_over_o, marching_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL over_ack: got %b, required 00",
               {game_over_o, marching_o});
    end
    fleet_right_i = 10'd100;
    fleet_bot_i   = 10'd100;
  endtask

  task automatic test_fire();
    int g0;
    apply_reset();
    alive_i       = 8'b1010_0101;
    bullet_busy_i = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(5);
    exp_q.push_back(7);
    exp_q.push_back(0);
    g0 = n_grants;
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      n_checks++;
      if (fire_grant_o === '0) begin
        n_fail++;
        $display("FAIL fire_slot%0d: got %b, required a grant",
                 k, fire_grant_o);
      end
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    n_checks++;
    if (n_grants - g0 != 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fire_count: got %0d grants, required 5",
               n_grants - g0);
    end
  endtask

  task automatic test_busy();
    int g0;
    apply_reset();
    alive_i       = '1;
    bullet_busy_i = 1'b1;
    g0 = n_grants;
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    n_checks++;
    if (n_grants != g0) begin
      n_fail++;
      $display("FAIL busy_hold: got %0d grants, required 0",
               n_grants - g0);
    end
    exp_q.push_back(0);
    @(posedge clk_i);
    #1;
    bullet_busy_i = 1'b0;
    frame_i       = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (fire_grant_o !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL busy_release: got %b, required 00000001",
               fire_grant_o);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
    n_checks++;
    if (n_grants - g0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL busy_single: got %0d grants, required 1",
               n_grants - g0);
    end
  endtask

  task automatic test_clear();
    apply_reset();
    alive_i       = '1;
    bullet_busy_i = 1'b1;
    fleet_right_i = 10'd625;
    fleet_left_i  = 10'd200;
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    n_checks++;
    if (dir_right_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_predir: got %b, required 0", dir_right_o);
    end
    fleet_right_i = 10'd100;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    frame_i = 1'b1;
    alive_i = '0;
    @(negedge clk_i);
    n_checks++;
    if ({step_o, drop_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_nostep: got %b, required 00",
               {step_o, drop_o});
    end
    cyc(1'b0, 1'b0);
    n_checks++;
    if ({wave_clear_o, marching_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL clear_level: got %b, required 10",
               {wave_clear_o, marching_o});
    end
    alive_i = '1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    n_checks++;
    if ({marching_o, dir_right_o, wave_clear_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL clear_restart: got %b, required 110",
               {marching_o, dir_right_o, wave_clear_o});
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    n_checks++;
    if (step_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_cnt2: got %b, required 0", step_o);
    end
    cyc(1'b1, 1'b0);
    n_checks++;
    if (step_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_cnt3: got %b, required 1", step_o);
    end
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_march();
    test_drop();
    test_over();
    test_fire();
    test_busy();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
